// File: rtl/switch_debouncer.sv
// Per-channel two-flop synchroniser plus stability counter producing a clean level and rise/fall pulses.
// Optional push-on/push-off latch output enabled by defining DEBOUNCE_TOGGLE_EN.
`timescale 1ns/1ps
module switch_debouncer #(
  parameter  int N_SW       = 2,
  parameter  int STABLE_CNT = 1000000,
  localparam int CNT_W      = $clog2(STABLE_CNT)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_SW-1:0] sw_i,
  output logic [N_SW-1:0] sw_clean_o,
  output logic [N_SW-1:0] sw_rise_o,
  output logic [N_SW-1:0] sw_fall_o
`ifdef DEBOUNCE_TOGGLE_EN
  ,
  output logic [N_SW-1:0] sw_toggle_o
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_ch
      logic             s1_q, s2_q;
      logic             clean_q, clean_d;
      logic             rise_q, rise_d;
      logic             fall_q, fall_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Any sample matching the clean level drops the count back to zero.
      always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q != clean_q) begin
          if (cnt_q == CNT_MAX) begin
            clean_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          cnt_q   <= '0;
          clean_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          s1_q    <= sw_i[gi];
          s2_q    <= s1_q;
          cnt_q   <= cnt_d;
          clean_q <= clean_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign sw_clean_o[gi] = clean_q;
      assign sw_rise_o[gi]  = rise_q;
      assign sw_fall_o[gi]  = fall_q;

`ifdef DEBOUNCE_TOGGLE_EN
      logic tog_q, tog_d;

      // Flips one cycle after each rise pulse.
      assign tog_d = tog_q ^ rise_q;

      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) tog_q <= 1'b0;
        else          tog_q <= tog_d;
      end

      assign sw_toggle_o[gi] = tog_q;
`endif
    end
  endgenerate

endmodule
